// File: rtl/l15_anycoredecoder_pkg.sv
// Shared encodings for the anycore -> L1.5 request bridge: PCX request types,
// MSG_DATA_SIZE codes, anycore store sizes, FSM states and slot identifiers.
package l15_anycoredecoder_pkg;

  localparam logic [4:0] PCX_REQTYPE_LOAD  = 5'b00000;
  localparam logic [4:0] PCX_REQTYPE_IFILL = 5'b10000;
  localparam logic [4:0] PCX_REQTYPE_STORE = 5'b00001;

  localparam logic [2:0] MSG_DATA_SIZE_1B  = 3'b001;
  localparam logic [2:0] MSG_DATA_SIZE_2B  = 3'b010;
  localparam logic [2:0] MSG_DATA_SIZE_4B  = 3'b011;
  localparam logic [2:0] MSG_DATA_SIZE_8B  = 3'b100;
  localparam logic [2:0] MSG_DATA_SIZE_32B = 3'b110;

  typedef enum logic [1:0] {
    ANY_SIZE_1B = 2'd0,
    ANY_SIZE_2B = 2'd1,
    ANY_SIZE_4B = 2'd2,
    ANY_SIZE_8B = 2'd3
  } any_size_e;

  typedef enum logic {
    DEC_IDLE = 1'b0,
    DEC_REQ  = 1'b1
  } dec_state_e;

  typedef enum logic [1:0] {
    SLOT_IC = 2'd0,
    SLOT_LD = 2'd1,
    SLOT_ST = 2'd2
  } slot_e;

  // Side of the most recent grant; the opposite side is favoured next.
  typedef enum logic {
    SIDE_IC = 1'b0,
    SIDE_DC = 1'b1
  } side_e;

  function automatic logic [2:0] store_msg_size(input any_size_e sz);
    case (sz)
      ANY_SIZE_1B: return MSG_DATA_SIZE_1B;
      ANY_SIZE_2B: return MSG_DATA_SIZE_2B;
      ANY_SIZE_4B: return MSG_DATA_SIZE_4B;
      default:     return MSG_DATA_SIZE_8B;
    endcase
  endfunction

endpackage

// File: rtl/l15_anycoredecoder_if.sv
// Anycore request inputs and L1.5 transducer request bus of the decoder.
// master = decoder side, slave = core/L1.5 environment side.
interface l15_anycoredecoder_if #(
  parameter int ADDR_W = 40
);
  logic              anycore_ic2mem_reqvalid;
  logic [ADDR_W-1:0] anycore_ic2mem_reqaddr;
  logic              anycore_dc2mem_ldvalid;
  logic [ADDR_W-1:0] anycore_dc2mem_ldaddr;
  logic              anycore_dc2mem_stvalid;
  logic [ADDR_W-1:0] anycore_dc2mem_staddr;
  logic [63:0]       anycore_dc2mem_stdata;
  logic [1:0]        anycore_dc2mem_stsize;
  logic              transducer_l15_val;
  logic [4:0]        transducer_l15_rqtype;
  logic              transducer_l15_nc;
  logic [2:0]        transducer_l15_size;
  logic [ADDR_W-1:0] transducer_l15_address;
  logic [63:0]       transducer_l15_data;
  logic              transducer_l15_threadid;
  logic              l15_transducer_ack;
  logic              anycoredecoder_busy;

  modport master (
    input  anycore_ic2mem_reqvalid, anycore_ic2mem_reqaddr,
    input  anycore_dc2mem_ldvalid, anycore_dc2mem_ldaddr,
    input  anycore_dc2mem_stvalid, anycore_dc2mem_staddr,
    input  anycore_dc2mem_stdata, anycore_dc2mem_stsize,
    input  l15_transducer_ack,
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
    output transducer_l15_size, transducer_l15_address, transducer_l15_data,
    output transducer_l15_threadid, anycoredecoder_busy
  );

  modport slave (
    output anycore_ic2mem_reqvalid, anycore_ic2mem_reqaddr,
    output anycore_dc2mem_ldvalid, anycore_dc2mem_ldaddr,
    output anycore_dc2mem_stvalid, anycore_dc2mem_staddr,
    output anycore_dc2mem_stdata, anycore_dc2mem_stsize,
    output l15_transducer_ack,
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
    input  transducer_l15_size, transducer_l15_address, transducer_l15_data,
    input  transducer_l15_threadid, anycoredecoder_busy
  );
endinterface

// File: rtl/l15_anycore_byteswap64.sv
// Combinational 8-byte reversal between anycore little-endian and L1.5 big-endian order.
module l15_anycore_byteswap64 (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  for (genvar i = 0; i < 8; i++) begin : g_byte
    assign dout[8*i +: 8] = din[8*(7-i) +: 8];
  end

endmodule

// File: rtl/l15_anycoredecoder.sv
// Anycore -> L1.5 request bridge: pending slots, ic/dc round-robin arbitration, field mapping.
// Define L15_ANYCORE_NC_WINDOW_EN to issue top-address-bit requests noncacheable (8B loads).
module l15_anycoredecoder
  import l15_anycoredecoder_pkg::*;
#(
  parameter int ADDR_W     = 40,
  parameter int LINE_OFF_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  l15_anycoredecoder_if.master bus
);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_OFF_W) - ADDR_W'(1));
`ifdef L15_ANYCORE_NC_WINDOW_EN
  localparam logic [ADDR_W-1:0] DW_MASK = ~ADDR_W'(7);
`endif

  logic              ic_pend_q, ic_pend_d, ld_pend_q, ld_pend_d, st_pend_q, st_pend_d;
  logic              ic_cap, ld_cap, st_cap, ic_clr, ld_clr, st_clr, ack_fire, any_pend;
  logic [ADDR_W-1:0] ic_addr_q, ld_addr_q, st_addr_q;
  logic [63:0]       st_data_q, st_data_swap;
  any_size_e         st_size_q;

  dec_state_e        state_q, state_d;
  side_e             rr_q, rr_d;
  slot_e             win_q, win_d, pick;

  logic              val_q, val_d, nc_q, nc_d;
  logic [4:0]        rqtype_q, rqtype_d;
  logic [2:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [63:0]       data_q, data_d;

  logic [4:0]        pick_rqtype;
  logic              pick_nc;
  logic [2:0]        pick_size;
  logic [ADDR_W-1:0] pick_addr;
  logic [63:0]       pick_data;

  l15_anycore_byteswap64 u_swap (
    .din  (st_data_q),
    .dout (st_data_swap)
  );

  // A slot may be re-armed in the very cycle its own request is acknowledged.
  always_comb begin
    ack_fire  = (state_q == DEC_REQ) && bus.l15_transducer_ack;
    ic_clr    = ack_fire && (win_q == SLOT_IC);
    ld_clr    = ack_fire && (win_q == SLOT_LD);
    st_clr    = ack_fire && (win_q == SLOT_ST);
    ic_cap    = bus.anycore_ic2mem_reqvalid && (!ic_pend_q || ic_clr);
    ld_cap    = bus.anycore_dc2mem_ldvalid  && (!ld_pend_q || ld_clr);
    st_cap    = bus.anycore_dc2mem_stvalid  && (!st_pend_q || st_clr);
    ic_pend_d = ic_cap || (ic_pend_q && !ic_clr);
    ld_pend_d = ld_cap || (ld_pend_q && !ld_clr);
    st_pend_d = st_cap || (st_pend_q && !st_clr);
    any_pend  = ic_pend_q || ld_pend_q || st_pend_q;
  end

  always_ff @(posedge clk) begin
    if (ic_cap) ic_addr_q <= bus.anycore_ic2mem_reqaddr;
    if (ld_cap) ld_addr_q <= bus.anycore_dc2mem_ldaddr;
    if (st_cap) begin
      st_addr_q <= bus.anycore_dc2mem_staddr;
      st_data_q <= bus.anycore_dc2mem_stdata;
      st_size_q <= any_size_e'(bus.anycore_dc2mem_stsize);
    end
  end

  // Store beats load to keep dcache ordering; ic vs dc alternates on the last-granted side.
  always_comb begin
    pick = st_pend_q ? SLOT_ST : SLOT_LD;
    if (ic_pend_q && (!(ld_pend_q || st_pend_q) || (rr_q == SIDE_DC))) pick = SLOT_IC;

    pick_rqtype = PCX_REQTYPE_LOAD;
    pick_size   = MSG_DATA_SIZE_32B;
    pick_addr   = ld_addr_q & LINE_MASK;
    pick_data   = '0;
    pick_nc     = 1'b0;
    case (pick)
      SLOT_IC: begin
        pick_rqtype = PCX_REQTYPE_IFILL;
        pick_addr   = ic_addr_q & LINE_MASK;
      end
      SLOT_ST: begin
        pick_rqtype = PCX_REQTYPE_STORE;
        pick_size   = store_msg_size(st_size_q);
        pick_addr   = st_addr_q;
        pick_data   = st_data_swap;
      end
      default: begin
      end
    endcase
`ifdef L15_ANYCORE_NC_WINDOW_EN
    case (pick)
      SLOT_IC: pick_nc = ic_addr_q[ADDR_W-1];
      SLOT_ST: pick_nc = st_addr_q[ADDR_W-1];
      default: pick_nc = ld_addr_q[ADDR_W-1];
    endcase
    if ((pick == SLOT_LD) && pick_nc) begin
      pick_size = MSG_DATA_SIZE_8B;
      pick_addr = ld_addr_q & DW_MASK;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    win_d    = win_q;
    val_d    = val_q;
    rqtype_d = rqtype_q;
    nc_d     = nc_q;
    size_d   = size_q;
    addr_d   = addr_q;
    data_d   = data_q;
    case (state_q)
      DEC_IDLE: begin
        if (any_pend) begin
          state_d  = DEC_REQ;
          val_d    = 1'b1;
          win_d    = pick;
          rr_d     = (pick == SLOT_IC) ? SIDE_IC : SIDE_DC;
          rqtype_d = pick_rqtype;
          nc_d     = pick_nc;
          size_d   = pick_size;
          addr_d   = pick_addr;
          data_d   = pick_data;
        end
      end
      default: begin
        if (bus.l15_transducer_ack) begin
          state_d = DEC_IDLE;
          val_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ic_pend_q <= 1'b0;
      ld_pend_q <= 1'b0;
      st_pend_q <= 1'b0;
      state_q   <= DEC_IDLE;
      rr_q      <= SIDE_IC;
      win_q     <= SLOT_IC;
      val_q     <= 1'b0;
      rqtype_q  <= '0;
      nc_q      <= 1'b0;
      size_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      ic_pend_q <= ic_pend_d;
      ld_pend_q <= ld_pend_d;
      st_pend_q <= st_pend_d;
      state_q   <= state_d;
      rr_q      <= rr_d;
      win_q     <= win_d;
      val_q     <= val_d;
      rqtype_q  <= rqtype_d;
      nc_q      <= nc_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign bus.transducer_l15_val      = val_q;
  assign bus.transducer_l15_rqtype   = rqtype_q;
  assign bus.transducer_l15_nc       = nc_q;
  assign bus.transducer_l15_size     = size_q;
  assign bus.transducer_l15_address  = addr_q;
  assign bus.transducer_l15_data     = data_q;
  assign bus.transducer_l15_threadid = 1'b0;
  assign bus.anycoredecoder_busy     = any_pend || (state_q == DEC_REQ);

`ifndef SYNTHESIS
  // The core never re-issues into a slot that is still pending.
  ic_repulse_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.anycore_ic2mem_reqvalid && ic_pend_q && !ic_clr));
  ld_repulse_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.anycore_dc2mem_ldvalid && ld_pend_q && !ld_clr));
  st_repulse_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.anycore_dc2mem_stvalid && st_pend_q && !st_clr));
`endif

endmodule

// File: tb/tb_l15_anycoredecoder.sv
// Bench for l15_anycoredecoder: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_l15_anycoredecoder;

`ifdef L15_ANYCORE_NC_WINDOW_EN
  localparam bit NC_EN = 1'b1;
`else
  localparam bit NC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l15_anycoredecoder_if #(.ADDR_W(40)) bus ();

  l15_anycoredecoder #(.ADDR_W(40), .LINE_OFF_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  rq;
    logic [2:0]  size;
    logic [39:0] addr;
    logic [63:0] data;
    logic        nc;
  } req_t;

  typedef struct {
    int          slot;   // 0 = ifill, 1 = load, 2 = store
    logic [39:0] addr;
    logic [63:0] data;
    logic [1:0]  sz;
    logic [4:0]  e_rq;
    logic [2:0]  e_size;
    logic [39:0] e_addr;
    logic [63:0] e_data;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Reference model state for the randomized phase
  bit   [2:0]  pend, snap;
  logic [39:0] paddr [3];
  logic [63:0] pdata [3];
  logic [1:0]  psz   [3];
  int          last_side, cur, idle_wait;
  bit          outst, just_acked;
  req_t        cur_req;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic req_t exp_req(input int slot, input logic [39:0] a,
                                   input logic [63:0] d, input logic [1:0] sz);
    req_t r;
    r.nc   = NC_EN ? a[39] : 1'b0;
    r.data = '0;
    case (slot)
      0: begin r.rq = 5'b10000; r.size = 3'b110; r.addr = a - (a % 40'd32); end
      1: begin
        r.rq = 5'b00000;
        if (r.nc) begin r.size = 3'b100; r.addr = a - (a % 40'd8); end
        else      begin r.size = 3'b110; r.addr = a - (a % 40'd32); end
      end
      default: begin
        r.rq = 5'b00001; r.size = 3'(sz) + 3'd1; r.addr = a; r.data = {<<8{d}};
      end
    endcase
    return r;
  endfunction

  // Winner rule: store over load; the side that did not win last goes first when both wait.
  function automatic int pick_slot(input bit [2:0] p, input int last);
    int dcw;
    dcw = p[2] ? 2 : 1;
    if (p[0] && (p[1] || p[2])) return (last == 0) ? dcw : 0;
    if (p[0]) return 0;
    if (p[1] || p[2]) return dcw;
    return -1;
  endfunction

  task automatic clear_pulses();
    bus.anycore_ic2mem_reqvalid = 1'b0;
    bus.anycore_dc2mem_ldvalid  = 1'b0;
    bus.anycore_dc2mem_stvalid  = 1'b0;
  endtask

  task automatic idle_inputs();
    clear_pulses();
    bus.anycore_ic2mem_reqaddr = '0;
    bus.anycore_dc2mem_ldaddr  = '0;
    bus.anycore_dc2mem_staddr  = '0;
    bus.anycore_dc2mem_stdata  = '0;
    bus.anycore_dc2mem_stsize  = '0;
    bus.l15_transducer_ack     = 1'b0;
  endtask

  task automatic pulse(input int slot, input logic [39:0] a, input logic [63:0] d, input logic [1:0] sz);
    case (slot)
      0: begin bus.anycore_ic2mem_reqvalid = 1'b1; bus.anycore_ic2mem_reqaddr = a; end
      1: begin bus.anycore_dc2mem_ldvalid = 1'b1; bus.anycore_dc2mem_ldaddr = a; end
      default: begin
        bus.anycore_dc2mem_stvalid = 1'b1; bus.anycore_dc2mem_staddr = a;
        bus.anycore_dc2mem_stdata = d; bus.anycore_dc2mem_stsize = sz;
      end
    endcase
  endtask

  task automatic check_req(input string name, input req_t e);
    chk({name, "_val"},    bus.transducer_l15_val, 1);
    chk({name, "_rqtype"}, bus.transducer_l15_rqtype, e.rq);
    chk({name, "_size"},   bus.transducer_l15_size, e.size);
    chk({name, "_addr"},   bus.transducer_l15_address, e.addr);
    chk({name, "_data"},   bus.transducer_l15_data, e.data);
    chk({name, "_nc"},     bus.transducer_l15_nc, e.nc);
    chk({name, "_tid"},    bus.transducer_l15_threadid, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_val(input string name, input int limit);
    int n;
    n = 0;
    while (!bus.transducer_l15_val && n < limit) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_wait_val"}, bus.transducer_l15_val, 1);
  endtask

  task automatic ack_once();
    bus.l15_transducer_ack = 1'b1;
    @(negedge clk);
    bus.l15_transducer_ack = 1'b0;
  endtask

  task automatic rnd_step(input bit allow_pulse, input bit ack_always);
    bit ack;
    clear_pulses();
    bus.l15_transducer_ack = 1'b0;
    snap = pend;
    just_acked = 1'b0;
    ack = outst && (ack_always || ($urandom_range(0, 2) == 0));
    if (ack) begin
      bus.l15_transducer_ack = 1'b1;
      pend[cur] = 1'b0;
      outst = 1'b0;
      just_acked = 1'b1;
    end
    if (allow_pulse) begin
      for (int s = 0; s < 3; s++) begin
        if (!pend[s] && ($urandom_range(0, 3) == 0)) begin
          paddr[s] = {8'($urandom), $urandom};
          pdata[s] = {$urandom, $urandom};
          psz[s]   = 2'($urandom_range(0, 3));
          pulse(s, paddr[s], pdata[s], psz[s]);
          pend[s] = 1'b1;
        end
      end
    end
    @(negedge clk);
    if (just_acked) begin
      chk("rnd_gap_val", bus.transducer_l15_val, 0);
    end else if (outst) begin
      check_req("rnd_hold", cur_req);
    end else if (bus.transducer_l15_val) begin
      int w;
      w = pick_slot(snap, last_side);
      if (w < 0) begin
        chk("rnd_spurious_val", bus.transducer_l15_val, 0);
      end else begin
        cur = w;
        cur_req = exp_req(w, paddr[w], pdata[w], psz[w]);
        outst = 1'b1;
        last_side = (w == 0) ? 0 : 1;
        check_req("rnd_issue", cur_req);
      end
    end
    if (!outst && (pend != 3'b000)) idle_wait++;
    else idle_wait = 0;
    if (idle_wait > 0) chk("rnd_latency", (idle_wait <= 2), 1);
    chk("rnd_busy", bus.anycoredecoder_busy, (pend != 3'b000) || outst);
  endtask

  vec_t tbl [6];

  initial begin
    req_t e;
    tbl[0] = '{2, 40'h80_0000_1008, 64'h1122_3344_5566_7788, 2'd3,
               5'b00001, 3'b100, 40'h80_0000_1008, 64'h8877_6655_4433_2211};
    tbl[1] = '{0, 40'h00_0000_403C, 64'h0, 2'd0,
               5'b10000, 3'b110, 40'h00_0000_4020, 64'h0};
    tbl[2] = '{1, 40'h12_3456_789F, 64'h0, 2'd0,
               5'b00000, 3'b110, 40'h12_3456_7880, 64'h0};
    tbl[3] = '{2, 40'h00_0000_0003, 64'h0000_0000_0000_00AB, 2'd0,
               5'b00001, 3'b001, 40'h00_0000_0003, 64'hAB00_0000_0000_0000};
    tbl[4] = '{2, 40'h00_1234_5672, 64'hDEAD_BEEF_CAFE_F00D, 2'd1,
               5'b00001, 3'b010, 40'h00_1234_5672, 64'h0DF0_FECA_EFBE_ADDE};
    tbl[5] = '{2, 40'h7F_FFFF_FFFC, 64'h0102_0304_0506_0708, 2'd2,
               5'b00001, 3'b011, 40'h7F_FFFF_FFFC, 64'h0807_0605_0403_0201};

    idle_inputs();
    repeat (2) @(negedge clk);
    chk("rst_val",    bus.transducer_l15_val, 0);
    chk("rst_rqtype", bus.transducer_l15_rqtype, 0);
    chk("rst_nc",     bus.transducer_l15_nc, 0);
    chk("rst_size",   bus.transducer_l15_size, 0);
    chk("rst_addr",   bus.transducer_l15_address, 0);
    chk("rst_data",   bus.transducer_l15_data, 0);
    chk("rst_busy",   bus.anycoredecoder_busy, 0);
    rst_n = 1'b1;

    // Single requests from the table: 2-cycle latency, fields, ack drop
    for (int i = 0; i < 6; i++) begin
      pulse(tbl[i].slot, tbl[i].addr, tbl[i].data, tbl[i].sz);
      @(negedge clk);
      clear_pulses();
      chk($sformatf("t%0d_lat1_val", i), bus.transducer_l15_val, 0);
      chk($sformatf("t%0d_lat1_busy", i), bus.anycoredecoder_busy, 1);
      @(negedge clk);
      e.rq = tbl[i].e_rq; e.size = tbl[i].e_size; e.addr = tbl[i].e_addr;
      e.data = tbl[i].e_data; e.nc = NC_EN & tbl[i].addr[39];
      check_req($sformatf("t%0d", i), e);
      ack_once();
      chk($sformatf("t%0d_ack_val", i), bus.transducer_l15_val, 0);
      chk($sformatf("t%0d_ack_busy", i), bus.anycoredecoder_busy, 0);
    end

    // Held request: 10 cycles without ack
    e = exp_req(2, 40'h00_0ABC_DEF0, 64'hA5A5_0000_FFFF_1234, 2'd3);
    pulse(2, 40'h00_0ABC_DEF0, 64'hA5A5_0000_FFFF_1234, 2'd3);
    @(negedge clk);
    clear_pulses();
    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      check_req($sformatf("held%0d", k), e);
      @(negedge clk);
    end
    check_req("held_last", e);
    ack_once();
    chk("held_drop", bus.transducer_l15_val, 0);

    // Contention from reset: expected issue order st, ic, ld
    do_reset();
    pulse(0, 40'h00_0000_1004, 64'h0, 2'd0);
    pulse(1, 40'h00_0000_2047, 64'h0, 2'd0);
    pulse(2, 40'h00_0000_3008, 64'h0011_2233_4455_6677, 2'd3);
    @(negedge clk);
    clear_pulses();
    wait_val("cont0", 4);
    check_req("cont_st", exp_req(2, 40'h00_0000_3008, 64'h0011_2233_4455_6677, 2'd3));
    ack_once();
    chk("cont_gap0", bus.transducer_l15_val, 0);
    wait_val("cont1", 4);
    check_req("cont_ic", exp_req(0, 40'h00_0000_1004, 64'h0, 2'd0));
    ack_once();
    chk("cont_gap1", bus.transducer_l15_val, 0);
    wait_val("cont2", 4);
    check_req("cont_ld", exp_req(1, 40'h00_0000_2047, 64'h0, 2'd0));
    ack_once();
    chk("cont_done_busy", bus.anycoredecoder_busy, 0);

    // Re-arm: new load pulsed in the ack cycle of the previous load
    pulse(1, 40'h00_0000_5555, 64'h0, 2'd0);
    @(negedge clk);
    clear_pulses();
    wait_val("rearm1", 4);
    check_req("rearm1", exp_req(1, 40'h00_0000_5555, 64'h0, 2'd0));
    pulse(1, 40'h00_0000_9999, 64'h0, 2'd0);
    ack_once();
    clear_pulses();
    chk("rearm_gap_val", bus.transducer_l15_val, 0);
    chk("rearm_gap_busy", bus.anycoredecoder_busy, 1);
    @(negedge clk);
    check_req("rearm2", exp_req(1, 40'h00_0000_9999, 64'h0, 2'd0));
    ack_once();

    // Asynchronous reset while a request is outstanding and another is pending
    pulse(0, 40'h00_0000_7000, 64'h0, 2'd0);
    pulse(2, 40'h00_0000_7100, 64'h1, 2'd0);
    @(negedge clk);
    clear_pulses();
    wait_val("arst", 4);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_val_async", bus.transducer_l15_val, 0);
    chk("arst_busy_async", bus.anycoredecoder_busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("arst_quiet%0d", k), bus.transducer_l15_val, 0);
    end
    chk("arst_quiet_busy", bus.anycoredecoder_busy, 0);
    pulse(1, 40'h00_0000_8020, 64'h0, 2'd0);
    @(negedge clk);
    clear_pulses();
    wait_val("arst_post", 4);
    check_req("arst_post", exp_req(1, 40'h00_0000_8020, 64'h0, 2'd0));
    ack_once();

    // Randomized traffic against the reference model
    do_reset();
    pend = '0; last_side = 0; cur = 0; idle_wait = 0; outst = 1'b0; just_acked = 1'b0;
    for (int c = 0; c < 2000; c++) rnd_step(1'b1, 1'b0);
    for (int c = 0; c < 40 && ((pend != 3'b000) || outst); c++) rnd_step(1'b0, 1'b1);
    clear_pulses();
    bus.l15_transducer_ack = 1'b0;
    @(negedge clk);
    chk("rnd_drain_busy", bus.anycoredecoder_busy, 0);
    chk("rnd_drain_val", bus.transducer_l15_val, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/l15_anycoredecoder.md
Name: l15_anycoredecoder

Overview:
- Request-side bridge between the anycore core and the L1.5 transducer interface; the response path is handled by the existing L1.5-to-anycore encoder.
- Captures anycore I-cache fill, D-cache line-load and D-cache store requests into pending slots.
- Arbitrates among pending slots and presents one request at a time to L1.5, holding it stable until acknowledged.
- Converts anycore sizes, line-aligns fill addresses, byte-swaps store data to L1.5 big-endian order, and sign-extends nothing (physical addresses pass through).

Parameters:
- ADDR_W, 40, physical address width (matches `L15_PADDR_MASK).
- LINE_OFF_W, 5, log2 of line size in bytes (32B lines) used for fill alignment.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous assert, active-low
- anycore_ic2mem_reqvalid  in  1  I-fill request pulse
- anycore_ic2mem_reqaddr  in  ADDR_W  I-fill address
- anycore_dc2mem_ldvalid  in  1  D-line load request pulse
- anycore_dc2mem_ldaddr  in  ADDR_W  load address
- anycore_dc2mem_stvalid  in  1  store request pulse
- anycore_dc2mem_staddr  in  ADDR_W  store address
- anycore_dc2mem_stdata  in  64  store data, little-endian
- anycore_dc2mem_stsize  in  2  0=1B, 1=2B, 2=4B, 3=8B
- transducer_l15_val  out  1  request valid
- transducer_l15_rqtype  out  5  `PCX_REQTYPE_IFILL / `PCX_REQTYPE_LOAD / `PCX_REQTYPE_STORE
- transducer_l15_nc  out  1  noncacheable
- transducer_l15_size  out  3  `MSG_DATA_SIZE_* encoding
- transducer_l15_address  out  ADDR_W  request address
- transducer_l15_data  out  64  store data, byte-swapped
- transducer_l15_threadid  out  1  always 0
- l15_transducer_ack  in  1  request accepted this cycle
- anycoredecoder_busy  out  1  any slot pending or a request outstanding

Behaviour:
- Reset: all pending flags 0, state IDLE, rr pointer = IC. val=0, rqtype=0, nc=0, size=0, address=0, data=0, busy=0.
- Pending slots (ic, ld, st): each stores one flag and its payload.
  - A valid pulse sets the flag and captures the payload at the next edge.
  - A pulse while the same slot is already pending is dropped. The core never issues one; an assertion fires in simulation.
- FSM, two states:
  - IDLE: if any flag is set, select a winner, register its fields onto the outputs, and go to REQ with val=1 from the next cycle. Latency is 2 cycles from an input pulse to val.
  - REQ: outputs held constant while val=1 and ack=0. On ack: clear the winner's flag, drop val, return to IDLE. No back-to-back issue, so there is a minimum 1 idle cycle between requests.
- Arbitration:
  - Store has priority over load, preserving dcache ordering.
  - dcache vs icache alternates via the rr pointer. The pointer flips to the other side after each granted request.
- Field mapping:
  - IFILL: address low LINE_OFF_W bits zeroed, size=`MSG_DATA_SIZE_32B.
  - LOAD: same alignment, size=`MSG_DATA_SIZE_32B.
  - STORE: address unchanged, size = 1B→3'b001, 2B→3'b010, 4B→3'b011, 8B→3'b100; data = byte-reversed stdata. Data is 0 for non-stores.
- Simultaneous events:
  - A new pulse in the same cycle as the ack of a different slot is captured.
  - A pulse in the same cycle as the ack of the same slot sets the flag again, so the new request is not lost.
- Reset mid-REQ: val drops immediately (async) and all pending requests are discarded.
- busy = |flags | (state==REQ).

Optional Feature:
- Macro: L15_ANYCORE_NC_WINDOW_EN.
- Defined: addresses with bit ADDR_W-1 set are issued with nc=1. Loads in this window use size=`MSG_DATA_SIZE_8B and are not line-aligned (8B aligned only).
- Undefined: nc is tied to 0 and all loads are line fills.

Decomposition:
- Shared package/header: request-type and MSG_DATA_SIZE codes, the anycore size enum, and the FSM state encodings.
- Sub-module l15_anycore_byteswap64: combinational 8-byte reversal. It is reused by the encoder side.

Test Plan:
- Single store: stvalid, staddr=0x80_0000_1008, stdata=0x1122334455667788, stsize=3 → val 2 cycles later, rqtype=STORE, size=3'b100, data=0x8877665544332211; ack → val=0 next cycle, busy=0.
- Ifill alignment: reqaddr=0x00_0000_403C → address=0x00_0000_4020, size=32B, rqtype=IFILL.
- Held request: withhold ack for 10 cycles → all outputs stable, val=1 throughout.
- Contention: ic, ld and st pulses in the same cycle → issue order st, ic, ld (rr alternation), each after its own ack.
- Re-arm: ld pulse in the ack cycle of the prior ld → second LOAD issued after one idle cycle.
- Async reset during REQ → val=0 before the next clock edge; no request is issued after release until a new pulse arrives.
